// File: rtl/instr_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encoding and
// byte-stream framing constants.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  localparam int unsigned HDR_LEN        = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_WIDTH      = 8 * HDR_LEN;
  localparam int unsigned BCNT_WIDTH     = $clog2(BYTES_PER_WORD);

  // States in which the stream is consumed and the core must stay held.
  function automatic logic is_session(input state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: parses a length-prefixed, XOR-checksummed
// stream and writes little-endian words into instruction memory.
//
// state | meaning
// IDLE  | waiting for start, core released
// LEN0  | expecting word count low byte
// LEN1  | expecting word count high byte, range check
// DATA  | assembling payload words, one write per 4 bytes
// CHECK | expecting checksum byte
// DONE  | session ok, done sticky until next start
// ERR   | bad length or checksum, error sticky until next start
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    word_idx_q, word_idx_d;
  logic [BCNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic [23:0]             word_buf_q, word_buf_d;
  logic [7:0]              csum_q, csum_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                    accept;
  logic [LEN_WIDTH-1:0]    len_full;
  logic                    last_byte_of_word;
  logic                    last_word;

  assign in_ready          = is_session(state_q);
  assign accept            = in_valid && in_ready;
  assign len_full          = {in_data, len_q[7:0]};
  assign last_byte_of_word = (byte_cnt_q == BCNT_WIDTH'(BYTES_PER_WORD - 1));
  assign last_word         = (word_idx_q == (len_q - LEN_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_buf_d  = word_buf_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_LEN0;
          len_d      = '0;
          word_idx_d = '0;
          byte_cnt_d = '0;
          word_buf_d = '0;
          csum_d     = '0;
        end
      end

      ST_LEN0: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = ST_LEN1;
        end
      end

      ST_LEN1: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = ST_CHECK;
          end else if (32'(len_full) > 32'(MEM_SIZE)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          if (last_byte_of_word) begin
            // Bytes arrive LSB first; the buffer shifts down so the 4th byte lands on top.
            mem_we_d    = 1'b1;
            mem_addr_d  = ADDR_WIDTH'({word_idx_q, 2'b00});
            mem_wdata_d = DATA_WIDTH'({in_data, word_buf_q});
            byte_cnt_d  = '0;
            word_idx_d  = word_idx_q + LEN_WIDTH'(1);
            if (last_word) begin
              state_d = ST_CHECK;
            end
          end else begin
            word_buf_d = {in_data, word_buf_q[23:8]};
            byte_cnt_d = byte_cnt_q + BCNT_WIDTH'(1);
          end
        end
      end

      ST_CHECK: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_idx_q  <= '0;
      byte_cnt_q  <= '0;
      word_buf_q  <= '0;
      csum_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_buf_q  <= word_buf_d;
      csum_q      <= csum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The last write lands one cycle after the FSM has left DATA; keep the core held for it.
  assign cpu_hold  = is_session(state_q) || mem_we_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: framing, length bounds, stalls, reset abort,
// and start-ignore behaviour.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  instr_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = mem_addr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_for_byte got=%b want=1 byte=%h", in_ready, b); end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Reset with start and a valid byte present, so reset priority is always exercised.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic test_reset();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL rst_cpu_hold got=%b want=0", cpu_hold); end
    total++; if ({done, error} !== 2'b00) begin bad++; $display("FAIL rst_status got=%b want=00", {done, error}); end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%b want=0", in_ready); end
  endtask

  task automatic test_basic();
    wr_cnt = 0;
    pulse_start();
    @(negedge clk);
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL basic_hold_len0 got=%b want=1", cpu_hold); end
    send_stream('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
    @(negedge clk);
    total++; if ({mem_we, cpu_hold} !== 2'b11) begin bad++; $display("FAIL basic_final_we_hold got=%b want=11", {mem_we, cpu_hold}); end
    send_byte(8'h31, 0);
    total++; if (wr_cnt !== 2) begin bad++; $display("FAIL basic_wr_cnt got=%0d want=2", wr_cnt); end
    total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013) begin bad++; $display("FAIL basic_wr0 got=%h:%h want=0:00000013", wr_addr[0], wr_data[0]); end
    total++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_wr1 got=%h:%h want=4:deadbeef", wr_addr[1], wr_data[1]); end
    total++; if ({done, error, cpu_hold, in_ready} !== 4'b1000) begin bad++; $display("FAIL basic_status got=%b want=1000", {done, error, cpu_hold, in_ready}); end
    total++; if (mem_addr !== 32'h4 || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_hold_last got=%h:%h want=4:deadbeef", mem_addr, mem_wdata); end
  endtask

  task automatic test_zero_len();
    wr_cnt = 0;
    pulse_start();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_cleared got=%b want=0", done); end
    send_stream('{8'h00, 8'h00, 8'h00}, 0);
    total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL zero_ok_status got=%b want=10", {done, error}); end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL zero_ok_writes got=%0d want=0", wr_cnt); end
    pulse_start();
    send_stream('{8'h00, 8'h00, 8'h01}, 0);
    total++; if ({done, error} !== 2'b01) begin bad++; $display("FAIL zero_bad_status got=%b want=01", {done, error}); end
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL zero_bad_writes got=%0d want=0", wr_cnt); end
  endtask

  task automatic test_overflow();
    wr_cnt = 0;
    pulse_start();
    total++; if (error !== 1'b0) begin bad++; $display("FAIL ovf_error_cleared got=%b want=0", error); end
    send_stream('{8'h01, 8'h02}, 0);
    total++; if ({error, done, cpu_hold, in_ready} !== 4'b1000) begin bad++; $display("FAIL ovf_status got=%b want=1000", {error, done, cpu_hold, in_ready}); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL ovf_writes got=%0d want=0", wr_cnt); end
    pulse_start();
    send_stream('{8'h00, 8'h02}, 0);
    total++; if ({error, in_ready, cpu_hold} !== 3'b011) begin bad++; $display("FAIL maxlen_accepted got=%b want=011", {error, in_ready, cpu_hold}); end
    do_reset();
  endtask

  task automatic test_gaps();
    for (int g = 0; g < 2; g++) begin
      wr_cnt = 0;
      pulse_start();
      send_stream('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, g);
      total++; if (wr_cnt !== 1) begin bad++; $display("FAIL gap%0d_wr_cnt got=%0d want=1", g, wr_cnt); end
      total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678) begin bad++; $display("FAIL gap%0d_wr0 got=%h:%h want=0:12345678", g, wr_addr[0], wr_data[0]); end
      total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL gap%0d_status got=%b want=10", g, {done, error}); end
    end
  endtask

  task automatic test_reset_mid();
    wr_cnt = 0;
    pulse_start();
    send_stream('{8'h01, 8'h00, 8'hAA, 8'hBB}, 0);
    do_reset();
    total++; if ({in_ready, cpu_hold, done, error} !== 4'b0000) begin bad++; $display("FAIL abort_status got=%b want=0000", {in_ready, cpu_hold, done, error}); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (wr_cnt !== 0) begin bad++; $display("FAIL abort_writes got=%0d want=0", wr_cnt); end
    pulse_start();
    send_stream('{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC9}, 0);
    total++; if (wr_cnt !== 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_resume got=%0d:%h:%h want=1:0:cafef00d", wr_cnt, wr_addr[0], wr_data[0]); end
    total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL abort_resume_status got=%b want=10", {done, error}); end
  endtask

  task automatic test_start_in_data();
    wr_cnt = 0;
    pulse_start();
    send_stream('{8'h02, 8'h00, 8'h01, 8'h02}, 0);
    pulse_start();
    @(negedge clk);
    total++; if ({in_ready, cpu_hold} !== 2'b11) begin bad++; $display("FAIL start_ignored_ready got=%b want=11", {in_ready, cpu_hold}); end
    send_stream('{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08}, 0);
    total++; if (wr_cnt !== 2) begin bad++; $display("FAIL start_ignored_wr_cnt got=%0d want=2", wr_cnt); end
    total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h04030201) begin bad++; $display("FAIL start_ignored_wr0 got=%h:%h want=0:04030201", wr_addr[0], wr_data[0]); end
    total++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h08070605) begin bad++; $display("FAIL start_ignored_wr1 got=%h:%h want=4:08070605", wr_addr[1], wr_data[1]); end
    total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL start_ignored_status got=%b want=10", {done, error}); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_zero_len();
    test_overflow();
    test_gaps();
    test_reset_mid();
    test_start_in_data();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
